// File: rtl/pipeline_stall_ctrl_if.sv
// Control/status bundle between the stall sequencer and the pipeline datapath.
// The sequencer takes the slave view; the pipeline (or a bench) drives through master.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic             hazard_in;
  logic             branch_taken;
  logic             mem_req;
  logic             mem_ready;
  logic             stat_clear;
  logic             freeze_if;
  logic             freeze_id;
  logic             flush_if_id;
  logic             hazard_out;
  logic             freeze_pipe;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_count;
  logic [1:0]       state;

  modport master (
    output hazard_in, branch_taken, mem_req, mem_ready, stat_clear,
    input  freeze_if, freeze_id, flush_if_id, hazard_out, freeze_pipe,
           mem_timeout, stall_count, state
  );

  modport slave (
    input  hazard_in, branch_taken, mem_req, mem_ready, stat_clear,
    output freeze_if, freeze_id, flush_if_id, hazard_out, freeze_pipe,
           mem_timeout, stall_count, state
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: memory wait beats branch flush beats
// RAW hazard. Controls are combinational from registered state plus current inputs.
//
//   state    | meaning
//   RUN      | normal flow; RAW hazard bubbles ID, taken branch flushes IF/ID
//   MEM_WAIT | whole pipe frozen until mem_ready; returns to ret_state
//   FLUSH    | extra IF/ID bubbles after a taken branch, fcnt cycles left
//   (3)      | unreachable; recovers to RUN
module pipeline_stall_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 1,
  parameter int unsigned MEM_TIMEOUT  = 15,
  parameter int unsigned CNT_W        = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  pipeline_stall_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_FLUSH    = 2'd2,
    S_BAD      = 2'd3
  } state_e;

  localparam int unsigned FCNT_W = $clog2(FLUSH_CYCLES + 1);
  localparam int unsigned TCNT_W = $clog2(MEM_TIMEOUT);
  localparam logic [FCNT_W-1:0] FCNT_RELOAD = FCNT_W'(FLUSH_CYCLES - 1);
  localparam logic [TCNT_W-1:0] TCNT_LAST   = TCNT_W'(MEM_TIMEOUT - 1);

  state_e             state_q, state_d;
  state_e             ret_state_q, ret_state_d;
  logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
  logic [TCNT_W-1:0]  tcnt_q, tcnt_d;
  logic [CNT_W-1:0]   stall_count_q, stall_count_d;

  logic freeze_if_c, freeze_id_c, flush_c, hazard_c, freeze_pipe_c, timeout_c;
  logic mem_stall;

  assign mem_stall = bus.mem_req & ~bus.mem_ready;

  always_comb begin
    state_d       = state_q;
    ret_state_d   = ret_state_q;
    fcnt_d        = fcnt_q;
    tcnt_d        = tcnt_q;
    freeze_if_c   = 1'b0;
    freeze_id_c   = 1'b0;
    flush_c       = 1'b0;
    hazard_c      = 1'b0;
    freeze_pipe_c = 1'b0;
    timeout_c     = 1'b0;

    case (state_q)
      S_RUN: begin
        if (mem_stall) begin
          freeze_if_c   = 1'b1;
          freeze_id_c   = 1'b1;
          freeze_pipe_c = 1'b1;
          state_d       = S_MEM_WAIT;
          ret_state_d   = S_RUN;
          tcnt_d        = '0;
        end else if (bus.branch_taken) begin
          flush_c  = 1'b1;
          hazard_c = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = S_FLUSH;
            fcnt_d  = FCNT_RELOAD;
          end
        end else begin
          hazard_c    = bus.hazard_in;
          freeze_if_c = bus.hazard_in;
          freeze_id_c = bus.hazard_in;
        end
      end

      // branch/hazard are ignored here: the frozen EXE stage presents them again
      S_MEM_WAIT: begin
        if (bus.mem_ready) begin
          state_d = ret_state_q;
          tcnt_d  = '0;
        end else begin
          freeze_if_c   = 1'b1;
          freeze_id_c   = 1'b1;
          freeze_pipe_c = 1'b1;
          if (tcnt_q == TCNT_LAST) begin
            timeout_c = 1'b1;
            tcnt_d    = '0;
          end else begin
            tcnt_d = tcnt_q + TCNT_W'(1);
          end
        end
      end

      S_FLUSH: begin
        if (mem_stall) begin
          freeze_if_c   = 1'b1;
          freeze_id_c   = 1'b1;
          freeze_pipe_c = 1'b1;
          state_d       = S_MEM_WAIT;
          ret_state_d   = S_FLUSH;
          tcnt_d        = '0;
        end else begin
          flush_c  = 1'b1;
          hazard_c = 1'b1;
          if (bus.branch_taken) begin
            fcnt_d = FCNT_RELOAD;
          end else begin
            fcnt_d = fcnt_q - FCNT_W'(1);
            if (fcnt_q == FCNT_W'(1)) state_d = S_RUN;
          end
        end
      end

      default: state_d = S_RUN;
    endcase
  end

  // Outputs are gated by reset so the combinational paths are also quiet in reset.
  assign bus.freeze_if   = rst & freeze_if_c;
  assign bus.freeze_id   = rst & freeze_id_c;
  assign bus.flush_if_id = rst & flush_c;
  assign bus.hazard_out  = rst & hazard_c;
  assign bus.freeze_pipe = rst & freeze_pipe_c;
  assign bus.mem_timeout = rst & timeout_c;
  assign bus.stall_count = stall_count_q;
  assign bus.state       = state_q;

  always_comb begin
    stall_count_d = stall_count_q;
    if (bus.stat_clear)
      stall_count_d = '0;
    else if ((bus.freeze_if | bus.freeze_pipe) && (stall_count_q != '1))
      stall_count_d = stall_count_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= S_RUN;
      ret_state_q   <= S_RUN;
      fcnt_q        <= '0;
      tcnt_q        <= '0;
      stall_count_q <= '0;
    end else begin
      state_q       <= state_d;
      ret_state_q   <= ret_state_d;
      fcnt_q        <= fcnt_d;
      tcnt_q        <= tcnt_d;
      stall_count_q <= stall_count_d;
    end
  end

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Bench for pipeline_stall_ctrl: two configurations share one stimulus stream and are
// compared every cycle against a cycle-level behavioural model of the stall rules.
module tb_pipeline_stall_ctrl;

  localparam int FC_A = 2, MT_A = 15, CW_A = 16;
  localparam int FC_B = 3, MT_B = 4,  CW_B = 5;

  logic clk = 1'b0;
  logic rst;
  logic hz, br, mreq, mrdy, sclr;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  pipeline_stall_ctrl_if #(.CNT_W(CW_A)) bus_a ();
  pipeline_stall_ctrl_if #(.CNT_W(CW_B)) bus_b ();

  assign bus_a.hazard_in = hz;   assign bus_b.hazard_in = hz;
  assign bus_a.branch_taken = br; assign bus_b.branch_taken = br;
  assign bus_a.mem_req = mreq;   assign bus_b.mem_req = mreq;
  assign bus_a.mem_ready = mrdy; assign bus_b.mem_ready = mrdy;
  assign bus_a.stat_clear = sclr; assign bus_b.stat_clear = sclr;

  pipeline_stall_ctrl #(.FLUSH_CYCLES(FC_A), .MEM_TIMEOUT(MT_A), .CNT_W(CW_A))
    dut_a (.clk(clk), .rst(rst), .bus(bus_a));
  pipeline_stall_ctrl #(.FLUSH_CYCLES(FC_B), .MEM_TIMEOUT(MT_B), .CNT_W(CW_B))
    dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  logic [5:0]  o_flags [2];
  logic [1:0]  o_state [2];
  logic [31:0] o_cnt   [2];

  assign o_flags[0] = {bus_a.freeze_if, bus_a.freeze_id, bus_a.flush_if_id,
                       bus_a.hazard_out, bus_a.freeze_pipe, bus_a.mem_timeout};
  assign o_flags[1] = {bus_b.freeze_if, bus_b.freeze_id, bus_b.flush_if_id,
                       bus_b.hazard_out, bus_b.freeze_pipe, bus_b.mem_timeout};
  assign o_state[0] = bus_a.state;
  assign o_state[1] = bus_b.state;
  assign o_cnt[0]   = {16'd0, bus_a.stall_count};
  assign o_cnt[1]   = {27'd0, bus_b.stall_count};

  // model: waiting on memory, flush cycles still owed, wait-cycle count, stall counter
  bit          m_wait [2];
  int          m_left [2];
  int          m_wcnt [2];
  int unsigned m_cnt  [2];

  function automatic int cfg_fc(input int i);   return (i == 0) ? FC_A : FC_B; endfunction
  function automatic int cfg_mt(input int i);   return (i == 0) ? MT_A : MT_B; endfunction
  function automatic int unsigned cfg_max(input int i);
    return (i == 0) ? ((1 << CW_A) - 1) : ((1 << CW_B) - 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_wait[i] = 1'b0; m_left[i] = 0; m_wcnt[i] = 0; m_cnt[i] = 0;
    end
  endtask

  task automatic model_step(input int i, output logic [5:0] ef, output logic [1:0] es,
                            output logic [31:0] ec);
    bit fi, fid, fl, hzo, fp, to;
    fi = 0; fid = 0; fl = 0; hzo = 0; fp = 0; to = 0;
    es = m_wait[i] ? 2'd1 : ((m_left[i] > 0) ? 2'd2 : 2'd0);
    ec = m_cnt[i];
    if (m_wait[i]) begin
      if (mrdy) begin
        m_wait[i] = 1'b0;
        m_wcnt[i] = 0;
      end else begin
        fi = 1; fid = 1; fp = 1;
        if (m_wcnt[i] == cfg_mt(i) - 1) begin to = 1; m_wcnt[i] = 0; end
        else m_wcnt[i]++;
      end
    end else if (mreq && !mrdy) begin
      fi = 1; fid = 1; fp = 1;
      m_wait[i] = 1'b1;
      m_wcnt[i] = 0;
    end else if (m_left[i] > 0 || br) begin
      fl = 1; hzo = 1;
      m_left[i] = br ? cfg_fc(i) - 1 : m_left[i] - 1;
    end else begin
      hzo = hz; fi = hz; fid = hz;
    end
    if (sclr) m_cnt[i] = 0;
    else if ((fi || fp) && m_cnt[i] < cfg_max(i)) m_cnt[i]++;
    ef = {fi, fid, fl, hzo, fp, to};
  endtask

  task automatic run_cycle(input bit h, input bit b, input bit r, input bit y, input bit c);
    logic [5:0]  ef;
    logic [1:0]  es;
    logic [31:0] ec;
    hz = h; br = b; mreq = r; mrdy = y; sclr = c;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      model_step(i, ef, es, ec);
      chk($sformatf("flags[%0d]", i), {26'd0, o_flags[i]}, {26'd0, ef});
      chk($sformatf("state[%0d]", i), {30'd0, o_state[i]}, {30'd0, es});
      chk($sformatf("count[%0d]", i), o_cnt[i], ec);
      chk($sformatf("flush_vs_freeze_id[%0d]", i), {31'd0, o_flags[i][3] & o_flags[i][4]}, 32'd0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s.flags[%0d]", tag, i), {26'd0, o_flags[i]}, 32'd0);
      chk($sformatf("%s.state[%0d]", tag, i), {30'd0, o_state[i]}, 32'd0);
      chk($sformatf("%s.count[%0d]", tag, i), o_cnt[i], 32'd0);
    end
  endtask

  initial begin
    hz = 0; br = 0; mreq = 0; mrdy = 0; sclr = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10 chk_all_zero("reset");
    hz = 1; br = 1; mreq = 1;
    #1 chk_all_zero("reset_gated");
    hz = 0; br = 0; mreq = 0;
    @(posedge clk); #1 rst = 1'b1;
    model_reset();

    // RAW hazard for two cycles
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    chk("hazard_two_cycles_count", o_cnt[0], 32'd2);

    // branch pulse, then idle
    run_cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) run_cycle(0, 0, 0, 0, 0);

    // memory wait of 3 cycles, then ready; also mem_req & mem_ready together
    run_cycle(0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) run_cycle(1, 1, 1, 0, 0);
    run_cycle(0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 0, 0);

    // mem_ready low for 20 cycles: timeout pulses
    for (int k = 0; k < 20; k++) run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 1, 0);
    run_cycle(0, 0, 0, 0, 0);

    // mem stall in the middle of a branch flush, resumes the remaining flush
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 1, 0);
    for (int k = 0; k < 3; k++) run_cycle(0, 0, 0, 0, 0);

    // second branch during flush reloads the flush counter
    run_cycle(0, 1, 0, 0, 0);
    run_cycle(0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++) run_cycle(0, 0, 0, 0, 0);

    // saturation of the narrow counter, then stat_clear priority
    run_cycle(0, 0, 0, 0, 1);
    for (int k = 0; k < 40; k++) run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    chk("saturated_count_b", o_cnt[1], 32'd31);
    run_cycle(0, 0, 1, 0, 1);
    run_cycle(0, 0, 1, 1, 0);

    // randomized traffic
    for (int k = 0; k < 3000; k++)
      run_cycle($urandom_range(3) == 0, $urandom_range(9) == 0, $urandom_range(9) < 3,
                $urandom_range(9) < 3, $urandom_range(49) == 0);

    // asynchronous reset in the middle of a memory wait
    run_cycle(0, 0, 1, 0, 0);
    run_cycle(0, 0, 1, 0, 0);
    hz = 1; br = 1; mreq = 1; mrdy = 0;
    #2 rst = 1'b0;
    #1 chk_all_zero("mid_wait_reset");
    @(posedge clk); #1 rst = 1'b1;
    model_reset();
    run_cycle(0, 0, 0, 0, 0);
    run_cycle(1, 0, 0, 0, 0);
    run_cycle(0, 0, 0, 0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
